// File: rtl/gremlin_hit_ctl.sv
// Gremlin collision / kill / respawn controller: once per frame, tests each gremlin
// against the car bounding box, disables hit gremlins for a frame count, and keeps score.
module gremlin_hit_ctl #(
  parameter int unsigned GREMW          = 16,
  parameter int unsigned GREMH          = 32,
  parameter int unsigned CARW           = 32,
  parameter int unsigned CARH           = 32,
  parameter int unsigned RESPAWN_FRAMES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        game_en,
  input  logic        score_clr,
  input  logic [10:0] car_xpos,
  input  logic [10:0] car_ypos,
  input  logic [23:0] grem0_in,
  input  logic [23:0] grem1_in,
  output logic        grem0_enable,
  output logic        grem1_enable,
  output logic        hit0,
  output logic        hit1,
  output logic [7:0]  score
);

  localparam int unsigned PW = 11;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 8;
  localparam int unsigned NG = 2;

  typedef enum logic {
    ALIVE = 1'b0,
    DEAD  = 1'b1
  } state_t;

  typedef struct packed {
    logic          color;
    logic [PW-1:0] xpos;
    logic [PW-1:0] ypos;
    logic          active;
  } grem_t;

  grem_t         w_grem [NG];
  state_t        r_state [NG];
  logic [CW-1:0] r_cnt [NG];
  logic [NG-1:0] r_hit;
  logic [SW-1:0] r_score;
  logic          r_vsync_d;

  logic          w_tick;
  logic [AW-1:0] w_car_x_lo;
  logic [AW-1:0] w_car_x_hi;
  logic [AW-1:0] w_car_y_lo;
  logic [AW-1:0] w_car_y_hi;
  logic [NG-1:0] w_overlap;
  logic [NG-1:0] w_hit_cond;
  logic [SW:0]   w_score_sum;
  logic [SW-1:0] w_score_next;
  logic          w_unused_color;

  assign w_grem[0] = grem_t'(grem0_in);
  assign w_grem[1] = grem_t'(grem1_in);
  assign w_unused_color = w_grem[0].color ^ w_grem[1].color;

  // Frame tick: first cycle vsync is seen high
  assign w_tick = vsync_in & ~r_vsync_d;

  // Car box bounds, 12-bit so the right/bottom edges never wrap
  assign w_car_x_lo = AW'(car_xpos);
  assign w_car_y_lo = AW'(car_ypos);
  assign w_car_x_hi = AW'(car_xpos) + AW'(CARW);
  assign w_car_y_hi = AW'(car_ypos) + AW'(CARH);

  // Strict inequalities: boxes that only share an edge do not collide
  always_comb begin
    w_overlap  = '0;
    w_hit_cond = '0;
    for (int n = 0; n < NG; n++) begin
      w_overlap[n] = (AW'(w_grem[n].xpos) < w_car_x_hi) &&
                     (w_car_x_lo < AW'(w_grem[n].xpos) + AW'(GREMW)) &&
                     (AW'(w_grem[n].ypos) < w_car_y_hi) &&
                     (w_car_y_lo < AW'(w_grem[n].ypos) + AW'(GREMH));
      w_hit_cond[n] = w_overlap[n] & w_grem[n].active & game_en & (r_state[n] == ALIVE);
    end
  end

  // Saturating score increment, one point per gremlin hit this tick
  assign w_score_sum  = {1'b0, r_score} + (SW+1)'(w_hit_cond[0]) + (SW+1)'(w_hit_cond[1]);
  assign w_score_next = w_score_sum[SW] ? {SW{1'b1}} : w_score_sum[SW-1:0];

  // Per-gremlin ALIVE/DEAD FSMs, respawn counters, hit pulses and score
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_hit     <= '0;
      r_score   <= '0;
      for (int n = 0; n < NG; n++) begin
        r_state[n] <= ALIVE;
        r_cnt[n]   <= '0;
      end
    end else begin
      r_vsync_d <= vsync_in;
      r_hit     <= '0;
      if (w_tick) begin
        for (int n = 0; n < NG; n++) begin
          case (r_state[n])
            ALIVE: begin
              if (w_hit_cond[n]) begin
                r_state[n] <= DEAD;
                r_cnt[n]   <= CW'(RESPAWN_FRAMES - 1);
                r_hit[n]   <= 1'b1;
              end
            end
            DEAD: begin
              if (r_cnt[n] != '0) begin
                r_cnt[n] <= r_cnt[n] - CW'(1);
              end else begin
                r_state[n] <= ALIVE;
              end
            end
            default: r_state[n] <= ALIVE;
          endcase
        end
      end
      if (score_clr) begin
        r_score <= '0;
      end else if (w_tick) begin
        r_score <= w_score_next;
      end
    end
  end

  assign grem0_enable = (r_state[0] == ALIVE);
  assign grem1_enable = (r_state[1] == ALIVE);
  assign hit0         = r_hit[0];
  assign hit1         = r_hit[1];
  assign score        = r_score;

endmodule

// File: tb/tb_gremlin_hit_ctl.sv
// Directed bench for gremlin_hit_ctl with a 3-frame respawn time.
module tb_gremlin_hit_ctl;

  logic        clk;
  logic        rst;
  logic        vsync_in;
  logic        game_en;
  logic        score_clr;
  logic [10:0] car_xpos;
  logic [10:0] car_ypos;
  logic [23:0] grem0_in;
  logic [23:0] grem1_in;
  logic        grem0_enable;
  logic        grem1_enable;
  logic        hit0;
  logic        hit1;
  logic [7:0]  score;

  int errors = 0;
  int checks = 0;

  gremlin_hit_ctl #(
    .GREMW(16), .GREMH(32), .CARW(32), .CARH(32), .RESPAWN_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .game_en(game_en), .score_clr(score_clr),
    .car_xpos(car_xpos), .car_ypos(car_ypos), .grem0_in(grem0_in), .grem1_in(grem1_in),
    .grem0_enable(grem0_enable), .grem1_enable(grem1_enable),
    .hit0(hit0), .hit1(hit1), .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [10:0] x, input logic [10:0] y, input logic act);
    return {1'b0, x, y, act};
  endfunction

  // Raise vsync; returns 1 time unit after the tick edge
  task automatic vs_rise();
    vsync_in = 1'b1;
    @(posedge clk); #1;
  endtask

  // Hold vsync one more cycle (must not re-tick), then drop it
  task automatic vs_fall();
    @(posedge clk); #1;
    vsync_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (grem0_enable !== 1'b1) begin errors++; $display("FAIL reset_en0 got=%b exp=1", grem0_enable); end
    checks++; if (grem1_enable !== 1'b1) begin errors++; $display("FAIL reset_en1 got=%b exp=1", grem1_enable); end
    checks++; if ({hit0, hit1} !== 2'b00) begin errors++; $display("FAIL reset_hit got=%b%b exp=00", hit0, hit1); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
  endtask

  task automatic test_no_collision();
    car_xpos = 11'd0; car_ypos = 11'd0;
    grem0_in = mk(11'd200, 11'd300, 1'b1);
    grem1_in = mk(11'd600, 11'd300, 1'b1);
    for (int i = 0; i < 3; i++) begin
      vs_rise();
      checks++;
      if ({grem0_enable, grem1_enable, hit0, hit1, score} !== {2'b11, 2'b00, 8'd0}) begin
        errors++;
        $display("FAIL idle_tick%0d got en=%b%b hit=%b%b score=%0d exp en=11 hit=00 score=0",
                 i, grem0_enable, grem1_enable, hit0, hit1, score);
      end
      vs_fall();
    end
  endtask

  task automatic test_hit();
    car_xpos = 11'd195; car_ypos = 11'd290;
    checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL hit_pre got=%b exp=0", hit0); end
    vs_rise();
    checks++; if (hit0 !== 1'b1) begin errors++; $display("FAIL hit_pulse got=%b exp=1", hit0); end
    checks++; if (grem0_enable !== 1'b0) begin errors++; $display("FAIL hit_en0 got=%b exp=0", grem0_enable); end
    checks++; if (grem1_enable !== 1'b1) begin errors++; $display("FAIL hit_en1 got=%b exp=1", grem1_enable); end
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL hit_score got=%0d exp=1", score); end
    @(posedge clk); #1;
    checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL hit_width got=%b exp=0", hit0); end
    vsync_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_respawn();
    // car still overlapping grem0
    for (int i = 1; i <= 3; i++) begin
      vs_rise();
      checks++;
      if ({grem0_enable, hit0, score} !== {(i == 3), 1'b0, 8'd1}) begin
        errors++;
        $display("FAIL respawn_tick%0d got en0=%b hit0=%b score=%0d exp en0=%b hit0=0 score=1",
                 i, grem0_enable, hit0, score, (i == 3));
      end
      vs_fall();
    end
    car_xpos = 11'd1000; car_ypos = 11'd1000;
  endtask

  task automatic test_edges();
    logic [10:0] cx [4];
    logic [10:0] cy [4];
    cx[0] = 11'd168; cy[0] = 11'd300;   // car right edge touches gremlin left edge
    cx[1] = 11'd216; cy[1] = 11'd300;   // car left edge touches gremlin right edge
    cx[2] = 11'd195; cy[2] = 11'd268;   // car bottom touches gremlin top
    cx[3] = 11'd195; cy[3] = 11'd332;   // car top touches gremlin bottom
    for (int i = 0; i < 4; i++) begin
      car_xpos = cx[i]; car_ypos = cy[i];
      vs_rise();
      checks++;
      if ({grem0_enable, hit0, score} !== {1'b1, 1'b0, 8'd1}) begin
        errors++;
        $display("FAIL edge_touch%0d got en0=%b hit0=%b score=%0d exp en0=1 hit0=0 score=1",
                 i, grem0_enable, hit0, score);
      end
      vs_fall();
    end
    car_xpos = 11'd169; car_ypos = 11'd300;
    vs_rise();
    checks++;
    if ({grem0_enable, hit0, score} !== {1'b0, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL edge_169 got en0=%b hit0=%b score=%0d exp en0=0 hit0=1 score=2",
               grem0_enable, hit0, score);
    end
    vs_fall();
    car_xpos = 11'd1000; car_ypos = 11'd1000;
    for (int i = 0; i < 3; i++) begin vs_rise(); vs_fall(); end
    checks++; if (grem0_enable !== 1'b1) begin errors++; $display("FAIL edge_revive got=%b exp=1", grem0_enable); end
  endtask

  task automatic test_game_disable();
    car_xpos = 11'd195; car_ypos = 11'd290;
    game_en = 1'b0;
    vs_rise();
    checks++;
    if ({grem0_enable, hit0, score} !== {1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL gameoff got en0=%b hit0=%b score=%0d exp en0=1 hit0=0 score=2",
               grem0_enable, hit0, score);
    end
    vs_fall();
    game_en = 1'b1;
  endtask

  task automatic test_score_clr();
    score_clr = 1'b1;
    vs_rise();
    score_clr = 1'b0;
    checks++;
    if ({grem0_enable, hit0, score} !== {1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL clr_hit got en0=%b hit0=%b score=%0d exp en0=0 hit0=1 score=0",
               grem0_enable, hit0, score);
    end
    vs_fall();
    // dead gremlin keeps counting with the game stopped
    game_en = 1'b0;
    for (int i = 0; i < 3; i++) begin vs_rise(); vs_fall(); end
    checks++; if (grem0_enable !== 1'b1) begin errors++; $display("FAIL clr_revive_gameoff got=%b exp=1", grem0_enable); end
    game_en = 1'b1;
  endtask

  task automatic test_back_to_back_saturate();
    car_xpos = 11'd195; car_ypos = 11'd290;
    grem1_in = mk(11'd210, 11'd300, 1'b1);
    for (int i = 0; i < 127; i++) begin
      vs_rise(); vs_fall();
      for (int k = 0; k < 3; k++) begin vs_rise(); vs_fall(); end
    end
    checks++; if (score !== 8'd254) begin errors++; $display("FAIL preload_score got=%0d exp=254", score); end
    for (int r = 0; r < 2; r++) begin
      vs_rise();
      checks++;
      if ({hit0, hit1, grem0_enable, grem1_enable, score} !== {4'b1100, 8'd255}) begin
        errors++;
        $display("FAIL double_hit%0d got hit=%b%b en=%b%b score=%0d exp hit=11 en=00 score=255",
                 r, hit0, hit1, grem0_enable, grem1_enable, score);
      end
      vs_fall();
      for (int k = 0; k < 3; k++) begin vs_rise(); vs_fall(); end
    end
  endtask

  task automatic test_reset_while_dead();
    grem1_in = mk(11'd600, 11'd300, 1'b1);
    vs_rise();
    checks++; if (grem0_enable !== 1'b0) begin errors++; $display("FAIL rstdead_pre got=%b exp=0", grem0_enable); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({grem0_enable, grem1_enable, hit0, hit1, score} !== {4'b1100, 8'd0}) begin
      errors++;
      $display("FAIL rstdead_async got en=%b%b hit=%b%b score=%0d exp en=11 hit=00 score=0",
               grem0_enable, grem1_enable, hit0, hit1, score);
    end
    @(posedge clk); #1;
    vsync_in = 1'b0;
    rst = 1'b0;
    car_xpos = 11'd1000; car_ypos = 11'd1000;
    vs_rise(); vs_fall();
    checks++; if ({grem0_enable, score} !== {1'b1, 8'd0}) begin errors++; $display("FAIL post_rst got en0=%b score=%0d exp en0=1 score=0", grem0_enable, score); end
  endtask

  initial begin
    rst = 1'b1; vsync_in = 1'b0; game_en = 1'b1; score_clr = 1'b0;
    car_xpos = '0; car_ypos = '0; grem0_in = '0; grem1_in = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_no_collision();
    test_hit();
    test_respawn();
    test_edges();
    test_game_disable();
    test_score_clr();
    test_back_to_back_saturate();
    test_reset_while_dead();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gremlin_hit_ctl.md
Name: gremlin_hit_ctl

Overview:
- Sits directly downstream of the gremlin position stage.
- Consumes the two packed gremlin status words plus the player car position, and detects car/gremlin bounding-box collisions once per frame.
- On a hit it kills the gremlin by dropping its enable, which feeds back into the position stage's grem0_enable/grem1_enable. It then runs a frame-based respawn countdown and maintains the run-over score.

Parameters:
- GREMW, 16, gremlin sprite width in pixels
- GREMH, 32, gremlin sprite height in pixels
- CARW, 32, car sprite width in pixels
- CARH, 32, car sprite height in pixels
- RESPAWN_FRAMES, 120, frames a killed gremlin stays disabled (1..255)

Ports:
- clk  in  1  pixel clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- vsync_in  in  1  VGA vsync from the timing bus; its rising edge is the frame tick
- game_en  in  1  high while a game is running; low ignores collisions
- score_clr  in  1  synchronous score clear
- car_xpos  in  11  car top-left x
- car_ypos  in  11  car top-left y
- grem0_in  in  24  gremlin 0 status: [23] color, [22:12] xpos, [11:1] ypos, [0] active
- grem1_in  in  24  gremlin 1 status, same packing
- grem0_enable  out  1  enable to gremlin 0 (high = alive)
- grem1_enable  out  1  enable to gremlin 1
- hit0  out  1  one-cycle pulse, gremlin 0 was hit
- hit1  out  1  one-cycle pulse, gremlin 1 was hit
- score  out  8  number of gremlins run over, saturating

Behaviour:
- Reset (async, rst=1):
  - both FSMs in ALIVE; grem0_enable = grem1_enable = 1
  - hit0 = hit1 = 0; score = 0; respawn counters = 0; vsync_d = 0
- Frame tick:
  - vsync_d is vsync_in registered.
  - tick = vsync_in & ~vsync_d, i.e. high for exactly one cycle, the first clk cycle vsync_in is seen high.
  - All state, score and counter updates happen only on the clk edge where tick = 1. The exception is score_clr, which acts on any cycle.
- Collision test for gremlin n, combinational, evaluated using inputs present in the tick cycle:
  - All arithmetic is 12-bit zero-extended, so there is no wrap.
  - gx = grem_n[22:12], gy = grem_n[11:1].
  - overlap_n = (gx < car_xpos+CARW) & (car_xpos < gx+GREMW) & (gy < car_ypos+CARH) & (car_ypos < gy+GREMH).
  - Edges that touch but do not overlap are not a hit.
  - hit_cond_n = overlap_n & grem_n[0] & game_en & (state_n == ALIVE).
- Per-gremlin FSM, states ALIVE and DEAD:
  - ALIVE, tick & hit_cond_n: go to DEAD, set cnt_n = RESPAWN_FRAMES-1, hit_n = 1 for the next cycle only.
  - DEAD, tick & cnt_n != 0: cnt_n decrements.
  - DEAD, tick & cnt_n == 0: go to ALIVE.
  - Result: the gremlin is disabled for exactly RESPAWN_FRAMES ticks.
  - DEAD continues counting while game_en = 0.
- Enables:
  - grem_n_enable = (state_n == ALIVE), driven from the state register, so it is glitch-free.
  - The enable falls on the clock edge following the tick cycle.
- Hit pulses: hit0/hit1 are registered and high for exactly 1 clk cycle, one cycle after the tick edge. They are never asserted while game_en = 0.
- Score:
  - On tick, score += hit_cond_0 + hit_cond_1; a simultaneous double hit adds 2.
  - Score saturates at 255; 254 plus a double hit gives 255.
  - score_clr = 1 sets score to 0 on that edge and wins over a same-cycle increment. FSMs and enables are unaffected by score_clr.
- vsync_in held high for many cycles generates only one tick. Ticks are not generated while rst = 1.
- Reset asserted mid-DEAD returns immediately to ALIVE with enable = 1 and the counter cleared.
- Latency summary: tick cycle to enable/score/hit change is 1 clk edge.

Test Plan:
- Reset release, car at (0,0), gremlins at (200,300) and (600,300), 3 vsync pulses -> enables stay 1, hit0/hit1 never assert, score = 0.
- Car at (195,290), grem0 active at (200,300), game_en = 1, one vsync rising edge -> hit0 high exactly 1 cycle after the tick edge, grem0_enable falls the same cycle, score = 1. grem1_enable stays 1.
- Continue from the previous hit with RESPAWN_FRAMES = 3 -> grem0_enable stays 0 for exactly 3 ticks, returns to 1 on the 3rd tick edge, no further score change while dead even with the car overlapping.
- Both gremlins overlapping the car on the same tick, with score preloaded to 254 via prior hits -> hit0 and hit1 pulse together, score = 255. A further double hit keeps score = 255.
- Touching-edge case: car_xpos = 168, CARW = 32, grem0 x = 200 -> no hit. car_xpos = 169 -> hit.
- game_en = 0 with overlap -> no hit and no score change. score_clr asserted in the same cycle as a hit edge -> score = 0. rst pulse while grem0 is DEAD -> grem0_enable = 1 immediately, async with no clk edge needed.
